keypad_scanner: RTL and testbench
=================================

Name: keypad_scanner

Overview:
- Scans a 4x4 matrix keypad and delivers debounced key codes to the CPU I/O layer.
- It is the input-side counterpart of the multiplexed 7-segment driver. It uses the same rotating active-low strobe scheme, but drives keypad columns and reads the rows back instead of driving digits.
- Each accepted keypress produces a single-cycle `key_valid` pulse with a 4-bit code, plus a level `key_held` that stays high while the key remains down.

Parameters:
- `SCAN_DIV`, default 1000: CLK cycles each column stays strobed. Must be >= 4 so the row synchronizer settles.
- `DEBOUNCE_SCANS`, default 4: number of consecutive full scans with identical result required to accept a press or a release. Must be >= 1.

Ports:
- `CLK` input 1: system clock; all logic on rising edge.
- `rst` input 1: synchronous, active-high reset.
- `row_in` input 4: keypad rows; active-low, pulled up externally, asynchronous to `CLK`.
- `col_ctrl` output 4: column strobe; exactly one bit low at all times.
- `key_code` output 4: code of the last accepted key, = row_index*4 + col_index.
- `key_valid` output 1: one-cycle pulse when a new key is accepted.
- `key_held` output 1: high while an accepted key is still pressed, until its debounced release.

Behaviour:
- Reset values: `col_ctrl`=4'b1110, `key_code`=0, `key_valid`=0, `key_held`=0. The FSM, all counters and the synchronizer flops clear. Reset mid-operation has the same effect, and no `key_valid` is emitted as a result of reset.
- `row_in` passes through a 2-flop synchronizer before any use.
- Column index `c` cycles 0,1,2,3,0,… and `col_ctrl` = ~(1<<c).
- A divider counts 0..`SCAN_DIV`-1. On the terminal count:
  - the synchronized rows are sampled into the scan accumulator for column `c`;
  - `c` then advances.
- Scan end is the terminal count with `c`=3, giving a scan period of 4*`SCAN_DIV` cycles. At scan end the accumulated 16 bits are classified:
  - NONE: no low bits;
  - SINGLE(code): exactly one low bit, code = row*4 + col;
  - MULTI: two or more low bits.
- The accumulator clears at the start of each scan.
- FSM states are IDLE, DEB_PRESS, PRESSED and DEB_RELEASE. The stability counter `stab` saturates at `DEBOUNCE_SCANS`. All transitions below are evaluated at scan end only.
  - IDLE:
    - SINGLE(k): capture candidate k, `stab`=1, go to DEB_PRESS. If `DEBOUNCE_SCANS`=1, accept immediately instead.
    - NONE or MULTI: stay in IDLE.
  - DEB_PRESS:
    - SINGLE(same k): `stab`++. When `stab` reaches `DEBOUNCE_SCANS`, accept the key.
    - SINGLE(different k'): restart with candidate k', `stab`=1.
    - NONE or MULTI: return to IDLE.
  - Accept: `key_code`<=k, `key_valid` pulses high for exactly the cycle after the accepting scan end, `key_held`<=1, go to PRESSED.
  - PRESSED:
    - NONE: `stab`=1, go to DEB_RELEASE. If `DEBOUNCE_SCANS`=1, release immediately.
    - SINGLE(any) or MULTI: stay in PRESSED. There is no rollover; a second key is ignored.
  - DEB_RELEASE:
    - NONE: `stab`++. At `DEBOUNCE_SCANS`, release.
    - Anything else: return to PRESSED, `key_held` stays 1.
  - Release: `key_held`<=0 in the cycle after the releasing scan end, go to IDLE. `key_code` holds its last value.
- `key_valid` is never high on two consecutive cycles and never asserts outside the cycle following a scan end.
- Press-to-`key_valid` latency: the key's first full scan end + (`DEBOUNCE_SCANS`-1) scans + 1 cycle, plus the 2-cycle synchronizer delay.

Decomposition:
- Shared package `io_pkg`:
  - state encoding `kp_state_t` (IDLE, DEB_PRESS, PRESSED, DEB_RELEASE);
  - `KP_COL_RESET`=4'b1110;
  - `KP_CODE_W`=4.
- One natural sub-module, `sync_2ff`, a parameterized-width 2-flop synchronizer used for `row_in`. It is reusable for the switch and button inputs.

Test Plan (`SCAN_DIV`=4, `DEBOUNCE_SCANS`=3, so one scan = 16 cycles):
- Reset check: hold `rst` 2 cycles with `row_in`=4'hF. Then `col_ctrl` follows 1110, 1101, 1011, 0111 with 4 cycles each and repeats. `key_valid`=0 and `key_held`=0 throughout.
- Clean press: drive row 2 low whenever `col_ctrl`=1101 (row 2, col 1) for 5 scans. Expect exactly one `key_valid` pulse at the end of the 3rd full scan, `key_code`=9, and `key_held`=1.
- Bounce: key row 2 / col 1 present, absent, then present on alternating scans for 6 scans. Expect no `key_valid`, and `key_held` stays 0.
- Release then new key: after the press of code 9, release for 3 scans. Expect `key_held` to fall after the 3rd NONE scan. Then press row 3 / col 3 for 3 scans. Expect `key_valid` with `key_code`=15.
- Multi-key: row 0/col 0 and row 1/col 2 pressed together for 5 scans. Expect no `key_valid`. In PRESSED holding code 9, adding a second key gives no new pulse and `key_held` stays 1.
- Reset mid-debounce: assert `rst` during the 2nd stable scan of code 5. Expect all outputs at reset values, and a fresh 3 scans needed before `key_valid`.

Source files
------------

// File: rtl/io_pkg.sv
// Shared definitions for the CPU I/O layer blocks.
//   kp_state_t   : keypad debounce FSM states
//   kp_scan_t    : classification of one complete 4x4 keypad scan
//   kp_classify  : reduces a 16-bit pressed map to NONE / SINGLE(code) / MULTI
package io_pkg;

  localparam logic [3:0] KP_COL_RESET = 4'b1110;
  localparam int unsigned KP_CODE_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    DEB_PRESS,
    PRESSED,
    DEB_RELEASE
  } kp_state_t;

  typedef enum logic [1:0] {
    KP_NONE,
    KP_SINGLE,
    KP_MULTI
  } kp_scan_t;

  typedef struct packed {
    kp_scan_t               kind;
    logic [KP_CODE_W-1:0]   code;
  } kp_result_t;

  // pressed[i] is high when key code i was seen low during the scan
  function automatic kp_result_t kp_classify(input logic [15:0] pressed);
    kp_result_t  res;
    int unsigned n;
    res.kind = KP_NONE;
    res.code = '0;
    n = 0;
    for (int unsigned i = 0; i < 16; i++) begin
      if (pressed[i]) begin
        n++;
        res.code = KP_CODE_W'(i);
      end
    end
    if (n == 1)
      res.kind = KP_SINGLE;
    else if (n > 1)
      res.kind = KP_MULTI;
    return res;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous level inputs (keypad rows,
// switches, buttons).
//   CLK  : destination clock
//   rst  : synchronous active-high reset, clears both stages
//   d    : asynchronous input bus
//   q    : synchronized output, two CLK cycles behind d
module sync_2ff #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             CLK,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge CLK) begin
    if (rst) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner with per-scan debouncing.
//   CLK       : system clock
//   rst       : synchronous active-high reset
//   row_in    : keypad rows, active-low, asynchronous
//   col_ctrl  : rotating active-low column strobe
//   key_code  : last accepted key, row*4 + col
//   key_valid : one-cycle pulse on key acceptance
//   key_held  : high from acceptance until debounced release
module keypad_scanner
  import io_pkg::*;
#(
  parameter int unsigned SCAN_DIV       = 1000,
  parameter int unsigned DEBOUNCE_SCANS = 4
) (
  input  logic                 CLK,
  input  logic                 rst,
  input  logic [3:0]           row_in,
  output logic [3:0]           col_ctrl,
  output logic [KP_CODE_W-1:0] key_code,
  output logic                 key_valid,
  output logic                 key_held
);

  localparam int unsigned DIV_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned STAB_W = $clog2(DEBOUNCE_SCANS + 1);

  logic [3:0]           row_s;
  logic [DIV_W-1:0]     div;
  logic [1:0]           col;
  logic [15:0]          acc;
  logic [15:0]          sample_bits;
  logic                 tc;
  logic                 scan_end;
  kp_result_t           scan_res;

  kp_state_t            state, state_n;
  logic [STAB_W-1:0]    stab, stab_n;
  logic [STAB_W:0]      stab_inc;
  logic                 stab_done;
  logic [KP_CODE_W-1:0] cand, cand_n;
  logic                 accept;
  logic                 rel_key;

  sync_2ff #(.WIDTH(4)) u_row_sync (
    .CLK (CLK),
    .rst (rst),
    .d   (row_in),
    .q   (row_s)
  );

  assign tc       = (div == DIV_W'(SCAN_DIV - 1));
  assign scan_end = tc && (col == 2'd3);

  // Accumulator with the current column's rows merged in; at scan end this
  // is the complete scan, so classification sees column 3 without waiting
  // an extra cycle.
  always_comb begin
    sample_bits = acc;
    for (int unsigned r = 0; r < 4; r++)
      sample_bits[{r[1:0], col}] = ~row_s[r];
  end

  assign scan_res = kp_classify(sample_bits);

  always_ff @(posedge CLK) begin
    if (rst) begin
      div      <= '0;
      col      <= '0;
      col_ctrl <= KP_COL_RESET;
      acc      <= '0;
    end else if (tc) begin
      div      <= '0;
      col      <= col + 2'd1;
      col_ctrl <= {col_ctrl[2:0], col_ctrl[3]};
      acc      <= scan_end ? '0 : sample_bits;
    end else begin
      div <= div + 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (rst) begin
      state     <= IDLE;
      stab      <= '0;
      cand      <= '0;
      key_code  <= '0;
      key_valid <= 1'b0;
      key_held  <= 1'b0;
    end else begin
      state     <= state_n;
      stab      <= stab_n;
      cand      <= cand_n;
      key_valid <= accept;
      if (accept) begin
        key_code <= cand_n;
        key_held <= 1'b1;
      end else if (rel_key) begin
        key_held <= 1'b0;
      end
    end
  end

  always_comb begin
    state_n   = state;
    stab_n    = stab;
    cand_n    = cand;
    accept    = 1'b0;
    rel_key   = 1'b0;
    stab_inc  = {1'b0, stab} + 1'b1;
    stab_done = (stab_inc >= (STAB_W + 1)'(DEBOUNCE_SCANS));
    if (scan_end) begin
      unique case (state)
        IDLE: begin
          if (scan_res.kind == KP_SINGLE) begin
            cand_n = scan_res.code;
            if (DEBOUNCE_SCANS == 1) begin
              accept  = 1'b1;
              state_n = PRESSED;
            end else begin
              stab_n  = STAB_W'(1);
              state_n = DEB_PRESS;
            end
          end
        end
        DEB_PRESS: begin
          if (scan_res.kind == KP_SINGLE) begin
            if (scan_res.code == cand) begin
              if (stab_done) begin
                stab_n  = STAB_W'(DEBOUNCE_SCANS);
                accept  = 1'b1;
                state_n = PRESSED;
              end else begin
                stab_n = stab_inc[STAB_W-1:0];
              end
            end else begin
              cand_n = scan_res.code;
              stab_n = STAB_W'(1);
            end
          end else begin
            state_n = IDLE;
          end
        end
        PRESSED: begin
          if (scan_res.kind == KP_NONE) begin
            if (DEBOUNCE_SCANS == 1) begin
              rel_key = 1'b1;
              state_n = IDLE;
            end else begin
              stab_n  = STAB_W'(1);
              state_n = DEB_RELEASE;
            end
          end
        end
        DEB_RELEASE: begin
          if (scan_res.kind == KP_NONE) begin
            if (stab_done) begin
              stab_n  = STAB_W'(DEBOUNCE_SCANS);
              rel_key = 1'b1;
              state_n = IDLE;
            end else begin
              stab_n = stab_inc[STAB_W-1:0];
            end
          end else begin
            state_n = PRESSED;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with SCAN_DIV=4, DEBOUNCE_SCANS=3
// (one scan = 16 cycles). A behavioural 4x4 switch matrix drives row_in
// from col_ctrl and the set of keys currently held down.
module tb_keypad_scanner;

  logic       CLK = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] row_in;
  logic [3:0] col_ctrl;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;

  logic [15:0] keys_down = '0;

  int check_cnt = 0;
  int err_cnt   = 0;

  always #5 CLK = ~CLK;

  keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE_SCANS(3)) dut (
    .CLK       (CLK),
    .rst       (rst),
    .row_in    (row_in),
    .col_ctrl  (col_ctrl),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_held  (key_held)
  );

  // Switch matrix: a pressed key pulls its row low while its column is strobed
  always_comb begin
    row_in = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys_down[r*4+c] && !col_ctrl[c])
          row_in[r] = 1'b0;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic apply_reset();
    rst = 1'b1;
    repeat (2) @(posedge CLK);
    #1 rst = 1'b0;
  endtask

  // Runs n whole scans; ticks counted from 1 after the call, sampled #1 after
  // each rising edge. Records pulse/held events for the caller to judge.
  task automatic run_scans(input int n, output int pulses, output int pulse_tick,
                           output int dbl, output int stray,
                           output int held_rise, output int held_fall);
    logic prev_v, prev_h;
    pulses = 0; pulse_tick = -1; dbl = 0; stray = 0;
    held_rise = -1; held_fall = -1;
    prev_v = 1'b0;
    prev_h = key_held;
    for (int t = 1; t <= n * 16; t++) begin
      @(posedge CLK);
      #1;
      if (key_valid) begin
        pulses++;
        if (pulse_tick < 0) pulse_tick = t;
        if (prev_v) dbl++;
        if (t % 16 != 0) stray++;
      end
      if (key_held && !prev_h && held_rise < 0) held_rise = t;
      if (!key_held && prev_h && held_fall < 0) held_fall = t;
      prev_v = key_valid;
      prev_h = key_held;
    end
  endtask

  task automatic test_reset();
    logic [3:0] exp_col;
    keys_down = '0;
    apply_reset();
    check_cnt++;
    if (col_ctrl !== 4'b1110 || key_code !== 4'd0 || key_valid !== 1'b0 || key_held !== 1'b0) begin
      err_cnt++;
      $display("FAIL reset_values: col=%b code=%0d valid=%b held=%b, expected 1110 0 0 0",
               col_ctrl, key_code, key_valid, key_held);
    end
    for (int t = 1; t <= 32; t++) begin
      @(posedge CLK);
      #1;
      case ((t / 4) % 4)
        0: exp_col = 4'b1110;
        1: exp_col = 4'b1101;
        2: exp_col = 4'b1011;
        default: exp_col = 4'b0111;
      endcase
      check_cnt++;
      if (col_ctrl !== exp_col || key_valid !== 1'b0 || key_held !== 1'b0) begin
        err_cnt++;
        $display("FAIL col_rotation t=%0d: col=%b valid=%b held=%b, expected %b 0 0",
                 t, col_ctrl, key_valid, key_held, exp_col);
      end
    end
  endtask

  task automatic test_clean_press();
    int p, pt, d, s, hr, hf;
    keys_down = 16'h0200;  // row 2, col 1 -> code 9
    run_scans(5, p, pt, d, s, hr, hf);
    check_cnt++;
    if (p !== 1 || pt !== 48) begin
      err_cnt++;
      $display("FAIL press_pulse: pulses=%0d at tick %0d, expected 1 at tick 48", p, pt);
    end
    check_cnt++;
    if (d !== 0 || s !== 0) begin
      err_cnt++;
      $display("FAIL press_pulse_shape: double=%0d stray=%0d, expected 0 0", d, s);
    end
    check_cnt++;
    if (key_code !== 4'd9 || key_held !== 1'b1 || hr !== 48) begin
      err_cnt++;
      $display("FAIL press_code: code=%0d held=%b rise=%0d, expected 9 1 48", key_code, key_held, hr);
    end
  endtask

  task automatic test_second_key_while_pressed();
    int p, pt, d, s, hr, hf;
    keys_down = 16'h0201;  // code 9 plus code 0
    run_scans(3, p, pt, d, s, hr, hf);
    check_cnt++;
    if (p !== 0 || hf !== -1 || key_held !== 1'b1 || key_code !== 4'd9) begin
      err_cnt++;
      $display("FAIL pressed_multi: pulses=%0d fall=%0d held=%b code=%0d, expected 0 -1 1 9",
               p, hf, key_held, key_code);
    end
    keys_down = 16'h0020;  // a different single key, code 5
    run_scans(2, p, pt, d, s, hr, hf);
    check_cnt++;
    if (p !== 0 || key_held !== 1'b1 || key_code !== 4'd9) begin
      err_cnt++;
      $display("FAIL pressed_other: pulses=%0d held=%b code=%0d, expected 0 1 9", p, key_held, key_code);
    end
  endtask

  task automatic test_release_new_key();
    int p, pt, d, s, hr, hf;
    keys_down = '0;
    run_scans(3, p, pt, d, s, hr, hf);
    check_cnt++;
    if (hf !== 48 || key_held !== 1'b0 || p !== 0 || key_code !== 4'd9) begin
      err_cnt++;
      $display("FAIL release: fall=%0d held=%b pulses=%0d code=%0d, expected 48 0 0 9",
               hf, key_held, p, key_code);
    end
    keys_down = 16'h8000;  // row 3, col 3 -> code 15
    run_scans(3, p, pt, d, s, hr, hf);
    check_cnt++;
    if (p !== 1 || pt !== 48 || key_code !== 4'd15 || key_held !== 1'b1) begin
      err_cnt++;
      $display("FAIL new_key: pulses=%0d tick=%0d code=%0d held=%b, expected 1 48 15 1",
               p, pt, key_code, key_held);
    end
    keys_down = '0;
    run_scans(3, p, pt, d, s, hr, hf);
    check_cnt++;
    if (hf !== 48 || key_held !== 1'b0 || key_code !== 4'd15) begin
      err_cnt++;
      $display("FAIL release_15: fall=%0d held=%b code=%0d, expected 48 0 15", hf, key_held, key_code);
    end
  endtask

  task automatic test_bounce();
    int p, pt, d, s, hr, hf;
    int total_p, total_h;
    total_p = 0;
    total_h = 0;
    for (int i = 0; i < 6; i++) begin
      keys_down = (i % 2 == 0) ? 16'h0200 : 16'h0000;
      run_scans(1, p, pt, d, s, hr, hf);
      total_p += p;
      if (hr >= 0) total_h++;
    end
    check_cnt++;
    if (total_p !== 0 || total_h !== 0 || key_held !== 1'b0 || key_code !== 4'd15) begin
      err_cnt++;
      $display("FAIL bounce: pulses=%0d held_rises=%0d held=%b code=%0d, expected 0 0 0 15",
               total_p, total_h, key_held, key_code);
    end
  endtask

  task automatic test_multi_idle();
    int p, pt, d, s, hr, hf;
    keys_down = 16'h0041;  // code 0 and code 6
    run_scans(5, p, pt, d, s, hr, hf);
    check_cnt++;
    if (p !== 0 || hr !== -1 || key_held !== 1'b0) begin
      err_cnt++;
      $display("FAIL multi_idle: pulses=%0d rise=%0d held=%b, expected 0 -1 0", p, hr, key_held);
    end
    keys_down = '0;
    run_scans(1, p, pt, d, s, hr, hf);
  endtask

  task automatic test_reset_mid_debounce();
    int p, pt, d, s, hr, hf;
    keys_down = 16'h0020;  // row 1, col 1 -> code 5
    run_scans(1, p, pt, d, s, hr, hf);
    repeat (8) begin
      @(posedge CLK);
      #1;
    end
    apply_reset();
    check_cnt++;
    if (col_ctrl !== 4'b1110 || key_code !== 4'd0 || key_valid !== 1'b0 || key_held !== 1'b0) begin
      err_cnt++;
      $display("FAIL mid_reset_values: col=%b code=%0d valid=%b held=%b, expected 1110 0 0 0",
               col_ctrl, key_code, key_valid, key_held);
    end
    run_scans(3, p, pt, d, s, hr, hf);
    check_cnt++;
    if (p !== 1 || pt !== 48 || key_code !== 4'd5 || key_held !== 1'b1) begin
      err_cnt++;
      $display("FAIL post_reset_press: pulses=%0d tick=%0d code=%0d held=%b, expected 1 48 5 1",
               p, pt, key_code, key_held);
    end
    keys_down = '0;
    run_scans(3, p, pt, d, s, hr, hf);
    check_cnt++;
    if (hf !== 48 || key_held !== 1'b0 || key_code !== 4'd5) begin
      err_cnt++;
      $display("FAIL post_reset_release: fall=%0d held=%b code=%0d, expected 48 0 5", hf, key_held, key_code);
    end
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_second_key_while_pressed();
    test_release_new_key();
    test_bounce();
    test_multi_idle();
    test_reset_mid_debounce();
    $display("Simulation finished: %0d checks, %0d errors", check_cnt, err_cnt);
    $finish;
  end

endmodule
